// File: rtl/div_sequencer_32.sv
// ---------------------------------------------------------------------------
// div_sequencer_32
//
// Sequential signed 32-bit divider. One combinational non-restoring array
// stage (array_division_block_8x32) resolves 8 quotient bits. The sequencer
// runs that stage four times, most significant dividend byte first, and then
// fixes up the remainder and the signs.
//
// Sequence for one operation (start sampled at edge N):
//   IDLE -(N)-> PREP -(N+1)-> ITER x4 -(N+5)-> FIX -(N+6)-> DONE -(N+7)-> IDLE
//   out_busy is high while the FSM is outside IDLE (cycles after N..N+6).
//   out_done is a registered pulse for the single cycle after edge N+7.
//
// Handshake: in_start is a request qualified only in IDLE. Any request seen
// in another state, including DONE, is dropped; the requester simply holds
// or re-raises in_start. Operands are captured on the accepting edge, so the
// inputs may change freely afterwards. Results are registered at the DONE
// edge and held until the next DONE edge.
//
// Optional feature (macro DIV_BY_ZERO_DETECT_EN):
//   defined   - a zero divisor is seen in PREP, the array passes and FIX are
//               skipped (DONE follows PREP), quotient = 0xFFFFFFFF,
//               remainder = dividend, out_div_zero = 1.
//   undefined - no detection; a zero divisor runs the full sequence, results
//               are meaningless, out_div_zero is tied to 0.
//
// Ports:
//   in_clk         clock, rising edge
//   in_reset       asynchronous active-high reset
//   in_start       operation request
//   in_dividend    signed dividend
//   in_divisor     signed divisor
//   out_busy       operation in progress
//   out_done       one-cycle completion pulse
//   out_quotient   signed quotient (truncated toward zero)
//   out_remainder  signed remainder (sign of the dividend)
//   out_div_zero   divisor-zero flag, valid with out_done
//   out_dbg_state  current FSM state encoding (debug/observability)
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// array_division_block_8x32
//
// Eight rows of non-restoring division on unsigned 32-bit magnitudes.
// The partial remainder entering the block is a 32-bit two's-complement value
// whose magnitude never exceeds the divisor. Only its low 31 bits travel in
// in_x; the sign bit is implied by in_mode (1 = previous remainder was
// non-negative, 0 = negative), which is exactly the last quotient bit of the
// previous pass (or 1 before the first pass, when the remainder is zero).
//
// Ports:
//   in_x          {partial remainder[30:0], next 8 dividend bits}
//   in_y          divisor magnitude
//   in_mode       1: first row subtracts, 0: first row adds
//   out_result    partial remainder after 8 rows (two's complement)
//   out_quotient  8 quotient bits, MSB first
// ---------------------------------------------------------------------------
module array_division_block_8x32 (
  input  logic [38:0] in_x,
  input  logic [31:0] in_y,
  input  logic        in_mode,
  output logic [31:0] out_result,
  output logic [7:0]  out_quotient
);

  // 34 bits cover 2*r + bit for r in [-2^31, 2^31-1] plus/minus a divisor
  // of up to 2^31 without overflow.
  logic [33:0] row_r [0:8];
  logic [33:0] row_p [0:7];
  logic [33:0] y_ext;

  assign y_ext = {2'b00, in_y};

  // Rebuild the full signed remainder: sign = ~in_mode.
  assign row_r[0] = {{3{~in_mode}}, in_x[38:8]};

  for (genvar g = 0; g < 8; g++) begin : g_row
    // Shift in the next dividend bit, MSB of the chunk first.
    assign row_p[g] = {row_r[g][32:0], in_x[7-g]};
    // Non-negative remainder subtracts the divisor, negative one adds it.
    assign row_r[g+1] = row_r[g][33] ? (row_p[g] + y_ext) : (row_p[g] - y_ext);
    assign out_quotient[7-g] = ~row_r[g+1][33];
  end

  assign out_result = row_r[8][31:0];

endmodule

module div_sequencer_32 (
  input  logic        in_clk,
  input  logic        in_reset,
  input  logic        in_start,
  input  logic [31:0] in_dividend,
  input  logic [31:0] in_divisor,
  output logic        out_busy,
  output logic        out_done,
  output logic [31:0] out_quotient,
  output logic [31:0] out_remainder,
  output logic        out_div_zero,
  output logic [2:0]  out_dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PREP = 3'd1,
    S_ITER = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t state_q, state_d;

  // Captured operands (signed, as presented).
  logic [31:0] dvd_q, dvd_d;
  logic [31:0] dvs_q, dvs_d;
  // Working magnitudes; dmag shifts left one byte per pass.
  logic [31:0] dmag_q, dmag_d;
  logic [31:0] ymag_q, ymag_d;
  // Partial remainder and quotient accumulator.
  logic [31:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  // Array first-row mode for the next pass.
  logic        mode_q, mode_d;
  logic [1:0]  pass_q, pass_d;
  // Registered results.
  logic [31:0] quotient_q, quotient_d;
  logic [31:0] remainder_q, remainder_d;
  logic        div_zero_q, div_zero_d;
  logic        done_q, done_d;
  logic        dz_q, dz_d;

  // Array stage connections.
  logic [38:0] arr_x;
  logic [31:0] arr_result;
  logic [7:0]  arr_quotient;

  logic [31:0] quo_signed;
  logic [31:0] rem_signed;

  assign arr_x = {rem_q[30:0], dmag_q[31:24]};

  array_division_block_8x32 u_array (
    .in_x         (arr_x),
    .in_y         (ymag_q),
    .in_mode      (mode_q),
    .out_result   (arr_result),
    .out_quotient (arr_quotient)
  );

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge in_clk or posedge in_reset) begin
    if (in_reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next state
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (in_start) state_d = S_PREP;
`ifdef DIV_BY_ZERO_DETECT_EN
      S_PREP: state_d = (dvs_q == 32'd0) ? S_DONE : S_ITER;
`else
      S_PREP: state_d = S_ITER;
`endif
      S_ITER: if (pass_q == 2'd3) state_d = S_FIX;
      S_FIX:  state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: outputs
  // -------------------------------------------------------------------------
  always_comb begin
    out_busy      = (state_q != S_IDLE);
    out_dbg_state = state_q;
  end

  assign out_done      = done_q;
  assign out_quotient  = quotient_q;
  assign out_remainder = remainder_q;
  assign out_div_zero  = div_zero_q;

  // Final sign application; the magnitude of -2^31 / -1 is 2^31, which
  // wraps to 0x80000000 without any special handling.
  assign quo_signed = (dvd_q[31] ^ dvs_q[31]) ? (32'd0 - quo_q) : quo_q;
  assign rem_signed = dvd_q[31] ? (32'd0 - rem_q) : rem_q;

  // -------------------------------------------------------------------------
  // Datapath next state
  // -------------------------------------------------------------------------
  always_comb begin
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    dmag_d      = dmag_q;
    ymag_d      = ymag_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    mode_d      = mode_q;
    pass_d      = pass_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    div_zero_d  = div_zero_q;
    done_d      = 1'b0;
    dz_d        = dz_q;

    case (state_q)
      S_IDLE: begin
        if (in_start) begin
          dvd_d = in_dividend;
          dvs_d = in_divisor;
        end
      end
      S_PREP: begin
        dmag_d = dvd_q[31] ? (32'd0 - dvd_q) : dvd_q;
        ymag_d = dvs_q[31] ? (32'd0 - dvs_q) : dvs_q;
        rem_d  = 32'd0;
        quo_d  = 32'd0;
        mode_d = 1'b1;
        pass_d = 2'd0;
`ifdef DIV_BY_ZERO_DETECT_EN
        dz_d   = (dvs_q == 32'd0);
`else
        dz_d   = 1'b0;
`endif
      end
      S_ITER: begin
        rem_d  = arr_result;
        quo_d  = {quo_q[23:0], arr_quotient};
        mode_d = arr_quotient[0];
        dmag_d = {dmag_q[23:0], 8'd0};
        pass_d = pass_q + 2'd1;
      end
      S_FIX: begin
        // Non-restoring leaves a negative remainder one divisor short.
        if (rem_q[31]) rem_d = rem_q + ymag_q;
      end
      S_DONE: begin
        done_d = 1'b1;
`ifdef DIV_BY_ZERO_DETECT_EN
        if (dz_q) begin
          quotient_d  = 32'hFFFF_FFFF;
          remainder_d = dvd_q;
          div_zero_d  = 1'b1;
        end else begin
          quotient_d  = quo_signed;
          remainder_d = rem_signed;
          div_zero_d  = 1'b0;
        end
`else
        quotient_d  = quo_signed;
        remainder_d = rem_signed;
        div_zero_d  = dz_q;
`endif
      end
      default: ;
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath registers
  // -------------------------------------------------------------------------
  always_ff @(posedge in_clk or posedge in_reset) begin
    if (in_reset) begin
      dvd_q       <= 32'd0;
      dvs_q       <= 32'd0;
      dmag_q      <= 32'd0;
      ymag_q      <= 32'd0;
      rem_q       <= 32'd0;
      quo_q       <= 32'd0;
      mode_q      <= 1'b1;
      pass_q      <= 2'd0;
      quotient_q  <= 32'd0;
      remainder_q <= 32'd0;
      div_zero_q  <= 1'b0;
      done_q      <= 1'b0;
      dz_q        <= 1'b0;
    end else begin
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      dmag_q      <= dmag_d;
      ymag_q      <= ymag_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      mode_q      <= mode_d;
      pass_q      <= pass_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      div_zero_q  <= div_zero_d;
      done_q      <= done_d;
      dz_q        <= dz_d;
    end
  end

endmodule

// File: tb/tb_div_sequencer_32.sv
// ---------------------------------------------------------------------------
// tb_div_sequencer_32
//
// Directed bench for div_sequencer_32: a table of hand-computed divisions
// applied in a loop (latency, busy window, results, hold), followed by
// hand-written sequences for reset mid-operation, start while busy and
// start during the DONE cycle.
// ---------------------------------------------------------------------------
module tb_div_sequencer_32;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_DONE = 3'd4;

  // -------------------------------------------------------------------------
  // Clock / reset / DUT
  // -------------------------------------------------------------------------
  logic        in_clk = 1'b0;
  logic        in_reset;
  logic        in_start;
  logic [31:0] in_dividend;
  logic [31:0] in_divisor;
  logic        out_busy;
  logic        out_done;
  logic [31:0] out_quotient;
  logic [31:0] out_remainder;
  logic        out_div_zero;
  logic [2:0]  out_dbg_state;

  always #5 in_clk = ~in_clk;

  div_sequencer_32 dut (
    .in_clk        (in_clk),
    .in_reset      (in_reset),
    .in_start      (in_start),
    .in_dividend   (in_dividend),
    .in_divisor    (in_divisor),
    .out_busy      (out_busy),
    .out_done      (out_done),
    .out_quotient  (out_quotient),
    .out_remainder (out_remainder),
    .out_div_zero  (out_div_zero),
    .out_dbg_state (out_dbg_state)
  );

  // -------------------------------------------------------------------------
  // Scoreboard counters and compare helper
  // -------------------------------------------------------------------------
  int vec_cnt = 0;
  int err_cnt = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // -------------------------------------------------------------------------
  // Vector table
  // -------------------------------------------------------------------------
  typedef struct {
    logic [31:0] dvd;
    logic [31:0] dvs;
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [31:0] dvd, input logic [31:0] dvs,
                              input logic [31:0] q, input logic [31:0] r,
                              input logic dz, input int lat);
    vec_t v;
    v.dvd = dvd; v.dvs = dvs; v.q = q; v.r = r; v.dz = dz; v.lat = lat;
    return v;
  endfunction

  // -------------------------------------------------------------------------
  // Driver: issue one start, return edges from start edge N to first out_done
  // (sampled at the negedge after edge N+lat) and whether busy stayed high.
  // Returns sitting at the negedge where out_done was seen.
  // -------------------------------------------------------------------------
  task automatic run_op(input logic [31:0] dvd, input logic [31:0] dvs,
                        output int lat, output logic busy_ok);
    @(negedge in_clk);
    in_start    = 1'b1;
    in_dividend = dvd;
    in_divisor  = dvs;
    @(negedge in_clk);          // edge N has sampled the start
    in_start    = 1'b0;
    in_dividend = $urandom;     // must not affect the captured operands
    in_divisor  = $urandom;
    lat     = -1;
    busy_ok = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (out_done) begin
        lat = k;
        break;
      end
      if (!out_busy) busy_ok = 1'b0;
      @(negedge in_clk);
    end
  endtask

  // -------------------------------------------------------------------------
  // Stimulus
  // -------------------------------------------------------------------------
  int          lat;
  logic        busy_ok;
  int          done_cnt;
  logic [31:0] hold_q;

  initial begin
    // Hand-computed expectations: truncation toward zero, remainder follows
    // the dividend sign.
    vecs.push_back(mk(32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 7));
    vecs.push_back(mk(-32'sd100,      32'd7,          32'hFFFF_FFF2,  32'hFFFF_FFFE,  1'b0, 7));
    vecs.push_back(mk(32'd100,        -32'sd7,        32'hFFFF_FFF2,  32'd2,          1'b0, 7));
    vecs.push_back(mk(-32'sd100,      -32'sd7,        32'd14,         32'hFFFF_FFFE,  1'b0, 7));
    vecs.push_back(mk(32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b0, 7));
    vecs.push_back(mk(32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          1'b0, 7));
    vecs.push_back(mk(32'h7FFF_FFFF,  32'h8000_0000,  32'd0,          32'h7FFF_FFFF,  1'b0, 7));
    vecs.push_back(mk(32'h8000_0000,  32'h8000_0000,  32'd1,          32'd0,          1'b0, 7));
    vecs.push_back(mk(32'h8000_0000,  32'd2,          32'hC000_0000,  32'd0,          1'b0, 7));
    vecs.push_back(mk(32'h7FFF_FFFF,  32'd1,          32'h7FFF_FFFF,  32'd0,          1'b0, 7));
    vecs.push_back(mk(32'd5,          32'd10,         32'd0,          32'd5,          1'b0, 7));
    vecs.push_back(mk(32'd0,          32'd3,          32'd0,          32'd0,          1'b0, 7));
    vecs.push_back(mk(32'd123456789,  32'd1000,       32'd123456,     32'd789,        1'b0, 7));
    vecs.push_back(mk(-32'sd123456789, 32'd1000,      32'hFFFE_1DC0,  32'hFFFF_FCEB,  1'b0, 7));
    vecs.push_back(mk(32'h7FFF_FFFF,  32'h0001_0000,  32'h0000_7FFF,  32'h0000_FFFF,  1'b0, 7));
`ifdef DIV_BY_ZERO_DETECT_EN
    vecs.push_back(mk(32'd1234,       32'd0,          32'hFFFF_FFFF,  32'd1234,       1'b1, 2));
`endif

    // Reset block
    in_reset    = 1'b1;
    in_start    = 1'b0;
    in_dividend = 32'd0;
    in_divisor  = 32'd0;
    repeat (3) @(negedge in_clk);
    check32("reset_busy",  {31'd0, out_busy},     32'd0);
    check32("reset_done",  {31'd0, out_done},     32'd0);
    check32("reset_quot",  out_quotient,          32'd0);
    check32("reset_rem",   out_remainder,         32'd0);
    check32("reset_dz",    {31'd0, out_div_zero}, 32'd0);
    check32("reset_state", {29'd0, out_dbg_state}, {29'd0, ST_IDLE});
    in_reset = 1'b0;
    @(negedge in_clk);

    // Table loop
    foreach (vecs[i]) begin
      run_op(vecs[i].dvd, vecs[i].dvs, lat, busy_ok);
      check32($sformatf("v%0d_latency", i), lat, vecs[i].lat);
      check32($sformatf("v%0d_busy_window", i), {31'd0, busy_ok}, 32'd1);
      check32($sformatf("v%0d_busy_at_done", i), {31'd0, out_busy}, 32'd0);
      check32($sformatf("v%0d_quot", i), out_quotient, vecs[i].q);
      check32($sformatf("v%0d_rem", i), out_remainder, vecs[i].r);
      check32($sformatf("v%0d_dz", i), {31'd0, out_div_zero}, {31'd0, vecs[i].dz});
      @(negedge in_clk);
      check32($sformatf("v%0d_done_pulse", i), {31'd0, out_done}, 32'd0);
      in_dividend = $urandom;
      repeat (2) @(negedge in_clk);
      check32($sformatf("v%0d_hold_quot", i), out_quotient, vecs[i].q);
    end

    // Start while busy is ignored: 100/7 then 50/5 raised at edge N+3.
    @(negedge in_clk);
    in_start = 1'b1; in_dividend = 32'd100; in_divisor = 32'd7;
    @(negedge in_clk);                    // after N
    in_start = 1'b0;
    repeat (2) @(negedge in_clk);         // after N+2
    in_start = 1'b1; in_dividend = 32'd50; in_divisor = 32'd5;
    @(negedge in_clk);                    // after N+3
    in_start = 1'b0;
    done_cnt = 0;
    for (int k = 0; k < 20; k++) begin
      if (out_done) done_cnt++;
      @(negedge in_clk);
    end
    check32("busy_start_done_count", done_cnt, 32'd1);
    check32("busy_start_quot", out_quotient, 32'd14);
    check32("busy_start_rem",  out_remainder, 32'd2);

    // Reset during ITER pass 2, then a fresh 9/3.
    @(negedge in_clk);
    in_start = 1'b1; in_dividend = 32'd100; in_divisor = 32'd7;
    @(negedge in_clk);                    // after N (PREP)
    in_start = 1'b0;
    repeat (3) @(negedge in_clk);         // after N+3: ITER pass 2
    #2 in_reset = 1'b1;
    #1;
    check32("midrst_busy",  {31'd0, out_busy},      32'd0);
    check32("midrst_done",  {31'd0, out_done},      32'd0);
    check32("midrst_quot",  out_quotient,           32'd0);
    check32("midrst_rem",   out_remainder,          32'd0);
    check32("midrst_state", {29'd0, out_dbg_state}, {29'd0, ST_IDLE});
    @(negedge in_clk);
    in_reset = 1'b0;
    done_cnt = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge in_clk);
      if (out_done) done_cnt++;
    end
    check32("midrst_no_done", done_cnt, 32'd0);
    run_op(32'd9, 32'd3, lat, busy_ok);
    check32("after_rst_latency", lat, 32'd7);
    check32("after_rst_quot", out_quotient, 32'd3);
    check32("after_rst_rem",  out_remainder, 32'd0);

    // Start held during the DONE cycle is taken one cycle later, in IDLE.
    @(negedge in_clk);
    in_start = 1'b1; in_dividend = 32'd100; in_divisor = 32'd7;
    @(negedge in_clk);                    // after N
    in_start = 1'b0;
    repeat (6) @(negedge in_clk);         // after N+6: DONE
    check32("done_cycle_state", {29'd0, out_dbg_state}, {29'd0, ST_DONE});
    in_start = 1'b1; in_dividend = 32'd9; in_divisor = 32'd3;
    @(negedge in_clk);                    // after N+7: first result
    check32("done_cycle_first_done", {31'd0, out_done}, 32'd1);
    check32("done_cycle_first_quot", out_quotient, 32'd14);
    @(negedge in_clk);                    // after N+8: second start taken
    in_start = 1'b0;
    in_dividend = 32'd77;
    lat = -1;
    for (int k = 1; k < 20; k++) begin
      @(negedge in_clk);
      if (out_done) begin
        lat = k;
        break;
      end
    end
    check32("done_cycle_second_latency", lat, 32'd7);
    check32("done_cycle_second_quot", out_quotient, 32'd3);
    check32("done_cycle_second_rem",  out_remainder, 32'd0);

    // Final report
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  // Absolute time bound in case a wait above never resolves.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/div_sequencer_32.md
DIV_SEQUENCER_32 -- requirements
Module: div_sequencer_32

Interface
REQ-001 SHALL have one parameter: none; all widths fixed at 32-bit operands and 8 quotient bits per pass.
REQ-002 in_clk  input  1  single clock; all state updates on rising edge.
REQ-003 in_reset  input  1  reset, asynchronous, active-high.
REQ-004 in_start  input  1  request; sampled only in IDLE.
REQ-005 in_dividend  input  32  signed two's-complement dividend.
REQ-006 in_divisor  input  32  signed two's-complement divisor.
REQ-007 out_busy  output  1  high from accepted start until done.
REQ-008 out_done  output  1  one-cycle completion pulse.
REQ-009 out_quotient  output  32  signed quotient (LO).
REQ-010 out_remainder  output  32  signed remainder (HI).
REQ-011 out_div_zero  output  1  divisor-zero flag, valid with out_done.

Function
REQ-012 SHALL instantiate exactly one array_division_block_8x32 and iterate it four passes, 8 quotient bits per pass, MSB chunk first.
REQ-013 Operands SHALL be converted to magnitudes in PREP; array sees unsigned 32-bit magnitudes only.
REQ-014 Per pass: in_x = {rem[30:0], dividend_chunk[7:0]}, in_y = |divisor|, in_mode = 1 on first pass, else bit 0 of previous pass out_quotient.
REQ-015 After each pass, rem SHALL load out_result and the 8-bit out_quotient SHALL shift into the quotient register LSB end.
REQ-016 FIX state: if rem[31]=1 then rem = rem + |divisor| (non-restoring correction).
REQ-017 Sign rules: quotient negated if operand signs differ; remainder takes dividend sign; truncation toward zero.
REQ-018 States: IDLE -> PREP -> ITER (4 passes, 2-bit counter 0..3) -> FIX -> DONE -> IDLE; no other transitions except reset.
REQ-019 Latency: start sampled at edge N; out_done high for exactly the cycle following edge N+7; out_busy high for cycles after edges N..N+6.
REQ-020 in_start while busy SHALL be ignored; operands SHALL be captured at the start edge and input changes afterwards ignored.
REQ-021 out_quotient/out_remainder/out_div_zero SHALL update only at the DONE edge and hold until the next DONE.
REQ-022 0x80000000 / 0xFFFFFFFF SHALL yield quotient 0x80000000, remainder 0 (wrap, no flag).
REQ-023 in_start high in the DONE cycle SHALL be accepted the next cycle (IDLE), not in DONE.

Reset
REQ-024 in_reset SHALL force IDLE immediately, irrespective of clock, including mid-operation; in-flight result discarded.
REQ-025 Reset values: out_busy=0, out_done=0, out_quotient=0, out_remainder=0, out_div_zero=0, pass counter=0.

Configuration
REQ-026 Macro DIV_BY_ZERO_DETECT_EN SHALL gate divide-by-zero handling.
REQ-027 Defined: divisor 0 detected in PREP, ITER/FIX skipped, DONE follows PREP (out_done after edge N+2), quotient 0xFFFFFFFF, remainder = dividend, out_div_zero=1.
REQ-028 Undefined: no detection logic; divisor 0 runs full 7-cycle sequence, out_div_zero constant 0, quotient/remainder unspecified.

Verification
REQ-029 100 / 7, start at edge N -> out_done at cycle after N+7, quotient 14, remainder 2, div_zero 0.
REQ-030 -100 / 7 -> quotient 0xFFFFFFF2, remainder 0xFFFFFFFE; 100 / -7 -> quotient 0xFFFFFFF2, remainder 2.
REQ-031 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0; 0xFFFFFFFF / 1 -> quotient 0xFFFFFFFF, remainder 0.
REQ-032 With DIV_BY_ZERO_DETECT_EN: 1234 / 0 -> out_done after edge N+2, quotient 0xFFFFFFFF, remainder 1234, div_zero 1.
REQ-033 Start 100/7, pulse in_reset during ITER pass 2, then start 9/3 -> outputs zero during reset, no done for first op, second op quotient 3, remainder 0.
REQ-034 Start 100/7, reassert in_start with 50/5 on edge N+3 -> ignored; single out_done with quotient 14, remainder 2.
